// File: rtl/iir_biquad_df1_if.sv
// Sample stream bundle for iir_biquad_df1: valid/ready input side, pulsed output side.
interface iir_biquad_df1_if #(
  parameter int DATA_W = 16
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_sample;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_sample;

  modport master (
    output in_valid,
    output in_sample,
    input  in_ready,
    input  out_valid,
    input  out_sample
  );

  modport slave (
    input  in_valid,
    input  in_sample,
    output in_ready,
    output out_valid,
    output out_sample
  );
endinterface

// File: rtl/iir_biquad_df1.sv
// Direct Form I biquad: one shared multiplier, five-tap sequential MAC, round + saturate.
// Optional sticky saturation flag port enabled by defining IIR_SAT_FLAG_EN.
module iir_biquad_df1 #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC   = 14,
  parameter int ACC_W  = 40,
  parameter int B0     = 4096,
  parameter int B1     = 8192,
  parameter int B2     = 4096,
  parameter int A1     = -8192,
  parameter int A2     = 0
) (
  input  logic clk,
  input  logic reset,
`ifdef IIR_SAT_FLAG_EN
  output logic sat_flag,
`endif
  iir_biquad_df1_if.slave bus
);

  localparam int PROD_W = COEF_W + DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [COEF_W-1:0] C_B0 = COEF_W'(B0);
  localparam logic signed [COEF_W-1:0] C_B1 = COEF_W'(B1);
  localparam logic signed [COEF_W-1:0] C_B2 = COEF_W'(B2);
  localparam logic signed [COEF_W-1:0] C_A1 = COEF_W'(A1);
  localparam logic signed [COEF_W-1:0] C_A2 = COEF_W'(A2);

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [ACC_W-1:0] f_round(input logic signed [ACC_W-1:0] acc);
    f_round = (acc + RND) >>> FRAC;
  endfunction

  function automatic logic signed [DATA_W-1:0] f_sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)
      f_sat = SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN)
      f_sat = SAT_MIN[DATA_W-1:0];
    else
      f_sat = v[DATA_W-1:0];
  endfunction

`ifdef IIR_SAT_FLAG_EN
  function automatic logic f_clip(input logic signed [ACC_W-1:0] v);
    f_clip = (v > SAT_MAX) || (v < SAT_MIN);
  endfunction
`endif

  logic        [1:0]        r_state;
  logic        [2:0]        r_k;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_x0, r_x1, r_x2, r_y1, r_y2;
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_sample;

  logic signed [DATA_W-1:0] w_data;
  logic signed [COEF_W-1:0] w_coef;
  logic                     w_sub;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_round;
  logic signed [DATA_W-1:0] w_sat;

  // Feedback taps are subtracted, so the stored A coefficients never need negating.
  always_comb begin
    w_data = r_x0;
    w_coef = C_B0;
    w_sub  = 1'b0;
    case (r_k)
      3'd1: begin w_data = r_x1; w_coef = C_B1; end
      3'd2: begin w_data = r_x2; w_coef = C_B2; end
      3'd3: begin w_data = r_y1; w_coef = C_A1; w_sub = 1'b1; end
      3'd4: begin w_data = r_y2; w_coef = C_A2; w_sub = 1'b1; end
      default: ;
    endcase
  end

  assign w_prod     = PROD_W'(w_data) * PROD_W'(w_coef);
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_round    = f_round(r_acc);
  assign w_sat      = f_sat(w_round);

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = r_out_valid;
  assign bus.out_sample = r_out_sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_k          <= 3'd0;
      r_acc        <= '0;
      r_x0         <= '0;
      r_x1         <= '0;
      r_x2         <= '0;
      r_y1         <= '0;
      r_y2         <= '0;
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_x0    <= bus.in_sample;
            r_acc   <= '0;
            r_k     <= 3'd0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
          r_k   <= r_k + 3'd1;
          if (r_k == 3'd4)
            r_state <= S_DONE;
        end
        S_DONE: begin
          r_out_sample <= w_sat;
          r_out_valid  <= 1'b1;
          r_x2         <= r_x1;
          r_x1         <= r_x0;
          r_y2         <= r_y1;
          r_y1         <= w_sat;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef IIR_SAT_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sat_flag <= 1'b0;
    else if (r_state == S_DONE && f_clip(w_round))
      sat_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_iir_biquad_df1.sv
// Self-checking bench for iir_biquad_df1: vector table, corner sequences, random vs. reference model.
module tb_iir_biquad_df1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  iir_biquad_df1_if #(.DATA_W(16)) ifa ();
  iir_biquad_df1_if #(.DATA_W(16)) ifb ();

`ifdef IIR_SAT_FLAG_EN
  logic sat_a, sat_b;
`endif

  iir_biquad_df1 dut_a (
    .clk   (clk),
    .reset (reset),
`ifdef IIR_SAT_FLAG_EN
    .sat_flag (sat_a),
`endif
    .bus   (ifa.slave)
  );

  iir_biquad_df1 #(.B0(16384), .B1(0), .B2(0), .A1(0), .A2(0)) dut_b (
    .clk   (clk),
    .reset (reset),
`ifdef IIR_SAT_FLAG_EN
    .sat_flag (sat_b),
`endif
    .bus   (ifb.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Reference model of the default filter, straight from the difference equation.
  longint m_x1, m_x2, m_y1, m_y2;
  bit     m_clip;

  task automatic model_reset();
    m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0; m_clip = 0;
  endtask

  function automatic int model_step(input int x);
    longint acc, r, y;
    acc = 64'sd4096 * x + 64'sd8192 * m_x1 + 64'sd4096 * m_x2 + 64'sd8192 * m_y1 - 64'sd0 * m_y2;
    r = (acc + 64'sd8192) >>> 14;
    if (r > 32767) begin y = 32767; m_clip = 1; end
    else if (r < -32768) begin y = -32768; m_clip = 1; end
    else y = r;
    m_x2 = m_x1; m_x1 = x; m_y2 = m_y1; m_y1 = y;
    return int'(y);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Offer one sample when ready, then wait for its output pulse; latency counted from the accept edge.
  task automatic send(input bit sel, input int x, output int y, output int lat);
    int  n;
    bit  rdy;
    y = 0; lat = -1; n = 0;
    rdy = sel ? ifb.in_ready : ifa.in_ready;
    while (!rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
      rdy = sel ? ifb.in_ready : ifa.in_ready;
    end
    if (!rdy) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    if (sel) begin ifb.in_valid = 1'b1; ifb.in_sample = 16'(x); end
    else     begin ifa.in_valid = 1'b1; ifa.in_sample = 16'(x); end
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (sel ? ifb.out_valid : ifa.out_valid) begin
        lat = i;
        y = sel ? int'(ifb.out_sample) : int'(ifa.out_sample);
        break;
      end
    end
    chk("latency", lat, 6);
  endtask

  task automatic send_a(input string name, input int x);
    int exp_y, y, lat;
    exp_y = model_step(x);
    send(1'b0, x, y, lat);
    chk(name, y, exp_y);
`ifdef IIR_SAT_FLAG_EN
    chk("sat_flag", sat_a, m_clip);
`endif
  endtask

  typedef struct {
    bit sel;
    int x;
    int y;
  } vec_t;

  vec_t vecs[8];
  int   exp_q[$];

  initial begin
    int y, lat, pulses, last_acc, lowcnt, smp, first_y, last_y;
    bit rdy;

    ifa.in_valid = 1'b0; ifa.in_sample = '0;
    ifb.in_valid = 1'b0; ifb.in_sample = '0;
    model_reset();

    vecs[0] = '{1'b0, 1000, 250};
    vecs[1] = '{1'b0, 0, 625};
    vecs[2] = '{1'b0, 0, 563};
    vecs[3] = '{1'b0, 0, 282};
    vecs[4] = '{1'b0, 0, 141};
    vecs[5] = '{1'b1, 16384, 16384};
    vecs[6] = '{1'b1, -5, -5};
    vecs[7] = '{1'b1, 0, 0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    // Reset while idle
    do_reset();
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_sample", ifa.out_sample, 0);
    chk("rst_in_ready", ifa.in_ready, 1);
`ifdef IIR_SAT_FLAG_EN
    chk("rst_sat_flag", sat_a, 0);
`endif
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ifa.out_valid || ifb.out_valid) pulses++;
    end
    chk("idle_pulses", pulses, 0);

    // Vector table: impulse response and unity passthrough
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].sel, vecs[i].x, y, lat);
      chk(vecs[i].sel ? "passthru" : "impulse", y, vecs[i].y);
    end
    repeat (3) @(posedge clk); #1;
    chk("out_hold", ifa.out_sample, 141);
    chk("out_valid_low", ifa.out_valid, 0);

    // Positive saturation
    do_reset();
    first_y = model_step(32767);
    model_reset();
    chk("pos_first_model", first_y, 8192);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        send(1'b0, 32767, y, lat);
        chk("pos_first", y, model_step(32767));
      end else begin
        send_a("pos_sat", 32767);
      end
      last_y = y;
    end
    chk("pos_clamp", ifa.out_sample, 32767);

    // Negative saturation
    do_reset();
    for (int i = 0; i < 10; i++) send_a("neg_sat", -32768);
    chk("neg_clamp", ifa.out_sample, -32768);

    // in_valid held high with an incrementing sample
    do_reset();
    exp_q.delete();
    last_acc = -1; lowcnt = 0;
    ifa.in_valid = 1'b1;
    for (int c = 0; c < 42; c++) begin
      smp = c * 100 - 2000;
      ifa.in_sample = 16'(smp);
      rdy = ifa.in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        if (last_acc >= 0) begin
          chk("tp_spacing", c - last_acc, 7);
          chk("tp_ready_low", lowcnt, 6);
        end
        last_acc = c;
        lowcnt = 0;
        exp_q.push_back(model_step(smp));
      end else begin
        lowcnt++;
      end
      if (ifa.out_valid) begin
        if (exp_q.size() == 0) chk("tp_extra_pulse", 1, 0);
        else chk("tp_out", ifa.out_sample, exp_q.pop_front());
      end
    end
    ifa.in_valid = 1'b0;
    chk("tp_pending", exp_q.size(), 0);

    // Reset during the MAC phase abandons the sample and clears history
    do_reset();
    ifa.in_valid = 1'b1; ifa.in_sample = 16'(1000);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (ifa.out_valid) pulses++;
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ifa.out_valid) pulses++;
    end
    chk("midop_pulses", pulses, 0);
    chk("midop_out_sample", ifa.out_sample, 0);
    send(1'b0, 1000, y, lat); chk("post_rst_0", y, 250);
    send(1'b0, 0, y, lat);    chk("post_rst_1", y, 625);
    send(1'b0, 0, y, lat);    chk("post_rst_2", y, 563);

    // Random samples with random idle gaps against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int x;
      case ($urandom_range(0, 5))
        0: x = 32767;
        1: x = -32768;
        default: x = int'($urandom_range(0, 65535)) - 32768;
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_a("random", x);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 0 want 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iir_biquad_df1.md
Name: iir_biquad_df1

Overview:
- Second-order IIR section, Direct Form I, directly downstream of the sine wave generator; consumes its 16-bit samples and produces filtered 16-bit samples.
- Uses one shared multiplier and a sequential multiply-accumulate over five taps, controlled by an FSM.
- A valid/ready input handshake throttles the upstream stage.
- Cascading instances builds higher-order IIR filters.

Parameters:
- DATA_W, 16, sample width (signed two's complement, in and out)
- COEF_W, 16, coefficient width (signed)
- FRAC, 14, coefficient fractional bits (Q2.14)
- ACC_W, 40, accumulator width (signed)
- B0, 4096, feed-forward tap x[n] (0.25)
- B1, 8192, feed-forward tap x[n-1] (0.5)
- B2, 4096, feed-forward tap x[n-2] (0.25)
- A1, -8192, feedback tap y[n-1] (-0.5)
- A2, 0, feedback tap y[n-2]

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_sample valid
- in_ready  out  1  block can accept a sample; high only in IDLE
- in_sample  in  DATA_W  signed input sample x[n]
- out_valid  out  1  one-cycle pulse, out_sample updated
- out_sample  out  DATA_W  signed filtered sample y[n], held between pulses

Behaviour:
- Transfer function: y[n] = (B0*x[n] + B1*x[n-1] + B2*x[n-2] - A1*y[n-1] - A2*y[n-2]) >> FRAC.
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
- Reset values:
  - state=IDLE
  - out_valid=0
  - out_sample=0
  - x1, x2, y1, y2 history = 0
  - accumulator=0
  - in_ready=1 once reset is released
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture in_sample into x0, clear accumulator, tap index k=0, go to MAC.
- MAC:
  - in_ready=0.
  - One tap per edge, k=0..4, in the order x0*B0, x1*B1, x2*B2, y1*(-A1), y2*(-A2).
  - Each product is a full COEF_W+DATA_W signed product, sign-extended to ACC_W and added.
  - After k=4, go to DONE.
- DONE:
  - Round: acc + 2^(FRAC-1), then arithmetic shift right by FRAC.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register result into out_sample; pulse out_valid for one cycle.
  - Shift history: x2<=x1, x1<=x0, y2<=y1, y1<=saturated result.
  - Go to IDLE.
- Timing:
  - Accept on edge T; MAC accumulates on edges T+1..T+5; DONE on edge T+6.
  - out_valid is high in the cycle after edge T+6, so latency is 6 clocks.
  - Next accept is possible on edge T+7, giving throughput of 1 sample per 7 clocks.
- in_valid while in_ready=0: ignored, no capture. Upstream must hold the sample or accept the loss.
- in_ready is decoded from the state register only, with no combinational path from in_valid.
- Feedback history always stores the saturated value, never the unsaturated accumulator.
- The accumulator never wraps for any input or coefficient at the given widths.
- Reset mid-operation (MAC or DONE): computation is abandoned, history is cleared, and no out_valid is produced.
- out_sample never changes except on a DONE edge or on reset.

Optional Feature:
- Macro: IIR_SAT_FLAG_EN.
- With the macro defined:
  - Adds output port sat_flag (1 bit, reset 0).
  - sat_flag is sticky and set on the DONE edge of any sample whose rounded value needed clamping.
  - Cleared only by reset.
- Without the macro: the port and logic are absent; saturation still applies to out_sample.

Test Plan:
- Reset asserted mid-idle -> out_valid=0, out_sample=0, in_ready=1 after release; no spurious pulses over 20 clocks.
- Default coefficients, impulse 1000 then zeros, each sample offered when in_ready=1 -> out_sample sequence 250, 625, 563, 282, 141.
  - Each out_valid pulse arrives exactly 6 clocks after its accept edge.
- Override B0=16384, others 0; inputs 16384, -5, 0 -> outputs 16384, -5, 0 (unity passthrough, history unused).
- Default coefficients, constant input 32767 -> first output 8192.
  - Later outputs rise and clamp at 32767, never wrapping negative.
  - With IIR_SAT_FLAG_EN, sat_flag=1 from the first clamped output onward.
  - Repeat with constant -32768 -> clamps at -32768.
- in_valid held high with an incrementing sample on every clock -> accepts only on edges where in_ready=1, every 7 clocks.
  - in_ready stays low 6 cycles after each accept; output sequence corresponds only to the accepted samples.
- Accept impulse 1000, assert reset at edge T+3 for 2 cycles -> no out_valid.
  - After release, a fresh impulse 1000 reproduces 250, 625, 563, proving the history was cleared.
